id_inst_queue: RTL and testbench
================================

Name: id_inst_queue

Overview:
- Parametrised instruction buffer between IF and the ID decoder. It replaces direct use of inst_sram_rdata in ID, so a fetched instruction is not lost while ID is stalled.
- Holds up to DEPTH {pc, inst} entries and presents the head to the decoder.
- Detects load-use hazards on the head and raises stallreq.
- Performs branch-redirect filtering with MIPS delay-slot preservation: keeps the delay slot, then drops every fetch until the branch target arrives.

Parameters:
DEPTH, 4, queue entries; power of 2, >= 2
PC_W, 32, pc width
INST_W, 32, instruction width

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-high
flush  in  1  global flush (exception/eret); empties queue
push  in  1  IF offers an entry this cycle
push_pc  in  PC_W  pc of offered entry
push_inst  in  INST_W  instruction of offered entry
in_ready  out  1  queue accepts a push this cycle
out_valid  out  1  head entry valid
out_pc  out  PC_W  head pc
out_inst  out  INST_W  head instruction
id_ready  in  1  ID/EX can take the head this cycle
br_taken  in  1  head is a taken branch/jump (from ID branch resolve)
br_target  in  PC_W  redirect target, valid with br_taken
ex_is_load  in  1  instruction in EX is a load
ex_waddr  in  5  EX destination register
stallreq  out  1  load-use hazard on head
drop  out  1  an offered push was discarded by the filter this cycle
count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst=1 at posedge): count=0, rd/wr pointers=0, state=NORMAL, ds_pc=0, tgt_pc=0.
  - Outputs after reset: out_valid=0, in_ready=1, stallreq=0, drop=0.
- Storage: circular array, wr_ptr/rd_ptr with $clog2(DEPTH) bits; both wrap modulo DEPTH.
- in_ready = (count < DEPTH). It does not depend on same-cycle pop, so there is no combinational path from id_ready to in_ready.
  - push with in_ready=0 is ignored: no write, drop=0. IF must hold the entry.
- Hazard: stallreq = out_valid & ex_is_load & (ex_waddr != 0) & (ex_waddr == out_inst[25:21] | ex_waddr == out_inst[20:16]).
- pop = out_valid & id_ready & ~stallreq. A popped entry leaves the queue at the next posedge.
- Simultaneous push and pop: both occur; count unchanged. When full, push is refused even if a pop occurs.
- Non-optional default latency: a pushed entry is visible at the head 1 cycle after acceptance.
- flush: highest priority. Next state is count=0, pointers=0, state=NORMAL. A same-cycle push or pop is discarded (drop=0).
- Filter FSM states: NORMAL, DS_PEND (awaiting delay slot, pc==ds_pc), TGT_PEND (awaiting target, pc==tgt_pc).
  - NORMAL: all accepted pushes are enqueued.
  - On pop & br_taken in NORMAL: ds_pc = out_pc+4 and tgt_pc = br_target.
    - Remaining entries are those after the head, including the same-cycle push as the youngest.
    - If the oldest remaining pc == ds_pc: keep only that entry, discard the rest, go to TGT_PEND.
    - Otherwise: discard all remaining, go to DS_PEND.
  - DS_PEND: an accepted push with pc==ds_pc is enqueued and the state goes to TGT_PEND. Any other accepted push is dropped (drop=1).
  - TGT_PEND: an accepted push with pc==tgt_pc is enqueued and the state goes to NORMAL. Others are dropped (drop=1).
  - br_taken on a pop while state != NORMAL (branch in delay slot) is ignored; the filter state is unchanged.
  - A dropped push still requires in_ready=1, and it never changes count.
- Outputs out_pc/out_inst when out_valid=0: don't-care, but must not be X after reset (array reset to 0).
- PC arithmetic: ds_pc = out_pc + 4 modulo 2^PC_W.

Optional Feature:
- Macro: ID_INST_QUEUE_BYPASS_EN.
- Defined:
  - When count==0, state==NORMAL and push&in_ready, the push is presented combinationally as the head in the same cycle: out_valid=1, out_pc=push_pc, out_inst=push_inst.
  - If it is popped in that cycle it is not written. Otherwise it is written and becomes the stored head.
  - Hazard and branch logic apply to the bypassed head identically.
- Undefined: 1-cycle minimum latency as above. No path from push to out_*.

Test Plan:
- Reset, push pc 0xBFC00000/0xBFC00004/0xBFC00008 with id_ready=1 -> heads appear in order one cycle later each; count peaks at 1; in_ready=1 throughout.
- id_ready=0, push 5 times (DEPTH=4) -> count=4 after 4 pushes; in_ready=0 on the 5th offer; entry 5 accepted only after one pop; FIFO order kept across pointer wrap.
- Head lw-dependent: out_inst=0x00432021 (addu $4,$2,$3), ex_is_load=1, ex_waddr=3 -> stallreq=1, no pop. ex_waddr=0 -> stallreq=0.
- Branch: head pc 0x100 popped with br_taken=1, br_target=0x200; queue holds pcs 0x104, 0x108 -> only 0x104 kept; push 0x10C -> drop=1; push 0x200 -> enqueued; state NORMAL.
- Branch with empty remainder: pop 0x100 br_taken, target 0x300 -> push 0x108 dropped, 0x104 enqueued, 0x108 dropped, 0x300 enqueued.
- flush with count=3 and simultaneous push -> next cycle count=0, out_valid=0, state NORMAL. With BYPASS_EN: empty queue, push 0x400 -> out_valid=1 same cycle.

Source files
------------

// File: rtl/id_inst_queue.sv
// IF->ID instruction queue: holds {pc,inst}, flags load-use hazards, filters fetches after a taken branch (keeps delay slot).
// Latency: 1 cycle push-to-head; 0 cycles when ID_INST_QUEUE_BYPASS_EN is defined and the queue is empty in NORMAL state.
// Backpressure: in_ready = (count < DEPTH), independent of same-cycle pop; a refused push must be held by IF.
module id_inst_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [PC_W-1:0]          push_pc,
  input  logic [INST_W-1:0]        push_inst,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [PC_W-1:0]          out_pc,
  output logic [INST_W-1:0]        out_inst,
  input  logic                     id_ready,
  input  logic                     br_taken,
  input  logic [PC_W-1:0]          br_target,
  input  logic                     ex_is_load,
  input  logic [4:0]               ex_waddr,
  output logic                     stallreq,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0]   P1   = AW'(1);
  localparam logic [AW-1:0]   P2   = AW'(2);
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);
  localparam logic [PC_W-1:0] FOUR = PC_W'(4);

  typedef enum logic [1:0] {NORMAL, DS_PEND, TGT_PEND} state_t;

  state_t            state, state_n;
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr, rd_n, wr_n, rd_p1, rd_p2;
  logic [CW-1:0]     count_n;
  logic [PC_W-1:0]   ds_pc, tgt_pc, ds_n, tgt_n, nxt_pc, oldest_pc;
  logic              acc, byp, pop, branch, filt_ok, we, wr_en, pop_st;
  logic              rem_stored, rem_push;

  assign in_ready = (count < FULL);
  assign acc      = push & in_ready;

`ifdef ID_INST_QUEUE_BYPASS_EN
  assign byp       = (count == '0) & (state == NORMAL) & acc;
  assign out_valid = (count != '0) | byp;
  assign out_pc    = byp ? push_pc   : pc_mem[rd_ptr];
  assign out_inst  = byp ? push_inst : inst_mem[rd_ptr];
`else
  assign byp       = 1'b0;
  assign out_valid = (count != '0);
  assign out_pc    = pc_mem[rd_ptr];
  assign out_inst  = inst_mem[rd_ptr];
`endif

  assign stallreq = out_valid & ex_is_load & (ex_waddr != 5'd0) &
                    ((ex_waddr == out_inst[25:21]) | (ex_waddr == out_inst[20:16]));
  assign pop      = out_valid & id_ready & ~stallreq;
  // Branches in a delay slot are ignored: only NORMAL state reacts.
  assign branch   = pop & br_taken & (state == NORMAL);

  assign rd_p1      = rd_ptr + P1;
  assign rd_p2      = rd_ptr + P2;
  assign nxt_pc     = out_pc + FOUR;
  assign rem_stored = (count > CW'(1));
  assign rem_push   = acc & ~byp;
  assign oldest_pc  = rem_stored ? pc_mem[rd_p1] : push_pc;

  always_comb begin
    state_n = state;
    count_n = count;
    rd_n    = rd_ptr;
    wr_n    = wr_ptr;
    ds_n    = ds_pc;
    tgt_n   = tgt_pc;
    we      = 1'b0;
    drop    = 1'b0;
    wr_en   = 1'b0;
    pop_st  = 1'b0;
    case (state)
      DS_PEND:  filt_ok = (push_pc == ds_pc);
      TGT_PEND: filt_ok = (push_pc == tgt_pc);
      default:  filt_ok = 1'b1;
    endcase

    if (flush) begin
      state_n = NORMAL;
      count_n = '0;
      rd_n    = '0;
      wr_n    = '0;
    end else if (branch) begin
      ds_n  = nxt_pc;
      tgt_n = br_target;
      if ((rem_stored | rem_push) && (oldest_pc == nxt_pc)) begin
        // Keep only the delay slot; when it is the push, count was 1 so wr_ptr == rd_p1.
        rd_n    = rd_p1;
        wr_n    = rd_p2;
        count_n = CW'(1);
        we      = ~rem_stored & rem_push;
        drop    = rem_stored & acc;
        state_n = TGT_PEND;
      end else begin
        rd_n    = byp ? rd_ptr : rd_p1;
        wr_n    = byp ? rd_ptr : rd_p1;
        count_n = '0;
        drop    = rem_push;
        state_n = DS_PEND;
      end
    end else begin
      wr_en  = acc & filt_ok & ~(byp & pop);
      pop_st = pop & ~byp;
      drop   = acc & ~filt_ok;
      we     = wr_en;
      if (wr_en) begin
        wr_n = wr_ptr + P1;
        if (state == DS_PEND)  state_n = TGT_PEND;
        if (state == TGT_PEND) state_n = NORMAL;
      end
      if (pop_st) rd_n = rd_p1;
      count_n = count + CW'(wr_en) - CW'(pop_st);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= NORMAL;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      ds_pc  <= '0;
      tgt_pc <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else begin
      state  <= state_n;
      count  <= count_n;
      rd_ptr <= rd_n;
      wr_ptr <= wr_n;
      ds_pc  <= ds_n;
      tgt_pc <= tgt_n;
      if (we) begin
        pc_mem[wr_ptr]   <= push_pc;
        inst_mem[wr_ptr] <= push_inst;
      end
    end
  end

endmodule

// File: tb/tb_id_inst_queue.sv
// Scoreboard bench for id_inst_queue (DEPTH=4): directed stimulus queues expected pops; a negedge monitor compares them.
module tb_id_inst_queue;

`ifdef ID_INST_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, push, id_ready, br_taken, ex_is_load;
  logic [31:0] push_pc, push_inst, br_target;
  logic [4:0]  ex_waddr;
  logic        in_ready, out_valid, stallreq, drop;
  logic [31:0] out_pc, out_inst;
  logic [2:0]  count;

  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  id_inst_queue #(.DEPTH(4), .PC_W(32), .INST_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push(push), .push_pc(push_pc), .push_inst(push_inst),
    .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .id_ready(id_ready), .br_taken(br_taken), .br_target(br_target),
    .ex_is_load(ex_is_load), .ex_waddr(ex_waddr),
    .stallreq(stallreq), .drop(drop), .count(count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {16'h2400, pc[15:0]};
  endfunction

  // Monitor: every real pop must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && id_ready && !stallreq) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_pop: got pc %h expected none", out_pc);
      end else begin
        ent_t e;
        e = sb.pop_front();
        if (out_pc === e.pc && out_inst === e.inst) n_pass++;
        else $display("FAIL pop_order: got %h/%h expected %h/%h", out_pc, out_inst, e.pc, e.inst);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic offer(input logic p, input logic [31:0] pc, input logic rdy);
    push = p; push_pc = pc; push_inst = inst_of(pc); id_ready = rdy;
  endtask

  task automatic expect_pop(input logic [31:0] pc, input logic [31:0] inst);
    ent_t e;
    e.pc = pc; e.inst = inst;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; flush = 0; push = 0; push_pc = 0; push_inst = 0; id_ready = 0;
    br_taken = 0; br_target = 0; ex_is_load = 0; ex_waddr = 0;
    step(); step();
    rst = 0;
    mid();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_stallreq",  {31'd0, stallreq},  32'd0);
    chk("rst_drop",      {31'd0, drop},      32'd0);
    chk("rst_count",     {29'd0, count},     32'd0);
    chk("rst_out_pc",    out_pc,             32'd0);
    step();

    // Streaming with id_ready=1: head one cycle after push
    offer(1, 32'hBFC00000, 1); expect_pop(32'hBFC00000, inst_of(32'hBFC00000));
    mid(); chk("s_valid0", {31'd0, out_valid}, {31'd0, BYP}); chk("s_rdy0", {31'd0, in_ready}, 32'd1);
    step();
    offer(1, 32'hBFC00004, 1); expect_pop(32'hBFC00004, inst_of(32'hBFC00004));
    mid(); chk("s_count1", {29'd0, count}, BYP ? 32'd0 : 32'd1); chk("s_rdy1", {31'd0, in_ready}, 32'd1);
    step();
    offer(1, 32'hBFC00008, 1); expect_pop(32'hBFC00008, inst_of(32'hBFC00008));
    mid(); chk("s_count2", {29'd0, count}, BYP ? 32'd0 : 32'd1);
    step();
    offer(0, 0, 1);
    mid(); step();
    offer(0, 0, 0);
    mid(); chk("s_empty", {29'd0, count}, 32'd0);
    step();

    // Fill to DEPTH, refuse 5th, accept after one pop, wrap pointers
    for (int i = 0; i < 5; i++) begin
      offer(1, 32'h1000 + 32'(4*i), 0);
      if (i < 4) expect_pop(32'h1000 + 32'(4*i), inst_of(32'h1000 + 32'(4*i)));
      mid(); chk("f_count", {29'd0, count}, 32'(i));
      if (i == 4) begin
        chk("f_rdy_full", {31'd0, in_ready}, 32'd0);
        chk("f_drop_full", {31'd0, drop}, 32'd0);
      end
      step();
    end
    offer(1, 32'h1010, 1);
    mid(); chk("f_rdy_pop", {31'd0, in_ready}, 32'd0); chk("f_cnt_pop", {29'd0, count}, 32'd4);
    step();
    offer(1, 32'h1010, 0); expect_pop(32'h1010, inst_of(32'h1010));
    mid(); chk("f_rdy_after", {31'd0, in_ready}, 32'd1); chk("f_cnt_after", {29'd0, count}, 32'd3);
    step();
    offer(0, 0, 0);
    mid(); chk("f_cnt_refill", {29'd0, count}, 32'd4);
    step();
    for (int i = 0; i < 4; i++) begin offer(0, 0, 1); mid(); step(); end
    offer(0, 0, 0);
    mid(); chk("f_drained", {29'd0, count}, 32'd0); chk("f_valid", {31'd0, out_valid}, 32'd0);
    step();

    // Load-use hazard on addu $4,$2,$3
    push = 1; push_pc = 32'h2000; push_inst = 32'h00432021; id_ready = 0;
    expect_pop(32'h2000, 32'h00432021);
    mid(); step();
    push = 0; ex_is_load = 1; ex_waddr = 5'd4;
    mid(); chk("h_rd_nostall", {31'd0, stallreq}, 32'd0);
    step();
    id_ready = 1; ex_waddr = 5'd3;
    mid(); chk("h_rt_stall", {31'd0, stallreq}, 32'd1);
    step();
    ex_waddr = 5'd2;
    mid(); chk("h_rs_stall", {31'd0, stallreq}, 32'd1); chk("h_held", {29'd0, count}, 32'd1);
    step();
    ex_waddr = 5'd0;
    mid(); chk("h_zero_nostall", {31'd0, stallreq}, 32'd0);
    step();
    ex_is_load = 0; id_ready = 0;
    mid(); chk("h_popped", {29'd0, count}, 32'd0);
    step();

    // Taken branch, delay slot already queued
    for (int i = 0; i < 3; i++) begin
      offer(1, 32'h100 + 32'(4*i), 0);
      mid(); step();
    end
    expect_pop(32'h100, inst_of(32'h100)); expect_pop(32'h104, inst_of(32'h104));
    offer(0, 0, 1); br_taken = 1; br_target = 32'h200;
    mid(); chk("b1_cnt3", {29'd0, count}, 32'd3);
    step();
    br_taken = 0; offer(1, 32'h10C, 0);
    mid(); chk("b1_drop10c", {31'd0, drop}, 32'd1); chk("b1_kept", {29'd0, count}, 32'd1);
    step();
    offer(1, 32'h200, 0); expect_pop(32'h200, inst_of(32'h200));
    mid(); chk("b1_tgt_nodrop", {31'd0, drop}, 32'd0);
    step();
    offer(1, 32'h204, 0); expect_pop(32'h204, inst_of(32'h204));
    mid(); chk("b1_normal", {31'd0, drop}, 32'd0); chk("b1_cnt2", {29'd0, count}, 32'd2);
    step();
    for (int i = 0; i < 3; i++) begin offer(0, 0, 1); mid(); step(); end
    offer(0, 0, 0);
    mid(); chk("b1_drained", {29'd0, count}, 32'd0);
    step();

    // Taken branch with nothing matching behind it
    offer(1, 32'h100, 0); expect_pop(32'h100, inst_of(32'h100));
    mid(); step();
    offer(1, 32'h108, 1); br_taken = 1; br_target = 32'h300;
    mid(); chk("b2_drop108a", {31'd0, drop}, 32'd1);
    step();
    br_taken = 0; offer(1, 32'h104, 0); expect_pop(32'h104, inst_of(32'h104));
    mid(); chk("b2_ds_keep", {31'd0, drop}, 32'd0); chk("b2_cnt0", {29'd0, count}, 32'd0);
    step();
    offer(1, 32'h108, 0);
    mid(); chk("b2_drop108b", {31'd0, drop}, 32'd1); chk("b2_cnt1", {29'd0, count}, 32'd1);
    step();
    offer(1, 32'h300, 0); expect_pop(32'h300, inst_of(32'h300));
    mid(); chk("b2_tgt", {31'd0, drop}, 32'd0);
    step();
    offer(0, 0, 0);
    mid(); chk("b2_cnt2", {29'd0, count}, 32'd2);
    step();
    for (int i = 0; i < 2; i++) begin offer(0, 0, 1); mid(); step(); end

    // Flush with three queued and a same-cycle push
    for (int i = 0; i < 3; i++) begin
      offer(1, 32'h500 + 32'(4*i), 0);
      mid(); step();
    end
    flush = 1; offer(1, 32'h50C, 0);
    mid(); chk("fl_cnt3", {29'd0, count}, 32'd3); chk("fl_drop", {31'd0, drop}, 32'd0);
    step();
    flush = 0; offer(0, 0, 0);
    mid(); chk("fl_cnt0", {29'd0, count}, 32'd0); chk("fl_valid", {31'd0, out_valid}, 32'd0);
    step();
    offer(1, 32'h600, 0); expect_pop(32'h600, inst_of(32'h600));
    mid(); chk("fl_normal", {31'd0, drop}, 32'd0);
    step();
    offer(0, 0, 0);
    mid(); chk("fl_cnt1", {29'd0, count}, 32'd1);
    step();
    offer(0, 0, 1); mid(); step();
    offer(0, 0, 0);

`ifdef ID_INST_QUEUE_BYPASS_EN
    offer(1, 32'h400, 0); expect_pop(32'h400, inst_of(32'h400));
    mid(); chk("byp_valid", {31'd0, out_valid}, 32'd1); chk("byp_pc", out_pc, 32'h400);
    step();
    offer(0, 0, 0);
    mid(); chk("byp_stored", {29'd0, count}, 32'd1);
    step();
    offer(0, 0, 1); mid(); step();
    offer(0, 0, 0);
`endif

    mid();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
